// File: rtl/serial_deserializer_if.sv
// Handshake and serial-stream signals of serial_deserializer, grouped as one bundle.
// The master side drives the serial stream and Ack; the slave side is the receiver.
interface serial_deserializer_if #(
  parameter int N = 8
);
  logic         SerIn;
  logic         SerEn;
  logic         Sync;
  logic         Ack;
  logic [N-1:0] Q;
  logic         Valid;
  logic         Overrun;
  logic         Busy;
  logic         ParErr;

  modport master (
    output SerIn, SerEn, Sync, Ack,
    input  Q, Valid, Overrun, Busy, ParErr
  );

  modport slave (
    input  SerIn, SerEn, Sync, Ack,
    output Q, Valid, Overrun, Busy, ParErr
  );
endinterface

// File: rtl/serial_deserializer.sv
// Strobed serial-to-parallel receiver (MSB first) with Valid/Ack handshake, sticky overrun and resync.
// Optional even-parity frame check is enabled by defining PARITY_CHECK_EN.
module serial_deserializer #(
  parameter int N = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  serial_deserializer_if.slave  bus
);

`ifdef PARITY_CHECK_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int CW = $clog2(F);
  // The final strobe of a frame goes straight into Q, so S only ever holds F-1 bits.
  localparam int SW = F - 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   s_q, s_d;
  logic [N-1:0]    q_q, q_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            complete;
`ifdef PARITY_CHECK_EN
  logic            parerr_q, parerr_d;
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    q_d       = q_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef PARITY_CHECK_EN
    parerr_d  = parerr_q;
`endif
    complete  = bus.SerEn && !bus.Sync && (cnt_q == CW'(F - 1));

    if (bus.Sync) begin
      // Resync beats completion; a coincident strobe becomes bit 1 of the new word.
      if (bus.SerEn) begin
        s_d     = SW'(bus.SerIn);
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else begin
        s_d     = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    end else if (bus.SerEn) begin
      s_d = (s_q << 1) | SW'(bus.SerIn);
      if (complete) begin
        cnt_d   = '0;
        state_d = IDLE;
`ifdef PARITY_CHECK_EN
        q_d      = s_q;
        parerr_d = ^{s_q, bus.SerIn};
`else
        q_d      = {s_q, bus.SerIn};
`endif
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = SHIFT;
      end
    end

    if (bus.Ack && valid_q && !complete) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (complete) begin
      valid_d = 1'b1;
      if (valid_q && !bus.Ack) overrun_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is asynchronous.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_q       <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      parerr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      parerr_q  <= parerr_d;
`endif
    end
  end

  assign bus.Q       = q_q;
  assign bus.Valid   = valid_q;
  assign bus.Overrun = overrun_q;
  assign bus.Busy    = (state_q == SHIFT);
`ifdef PARITY_CHECK_EN
  assign bus.ParErr  = parerr_q;
`else
  assign bus.ParErr  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: table-driven frames plus hand-written corner sequences.
// Define PARITY_CHECK_EN for both bench and RTL to exercise the parity frame.
module tb_serial_deserializer;

  localparam int N = 8;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;

  serial_deserializer_if #(.N(N)) bus ();
  serial_deserializer #(.N(N)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [N-1:0] exp_q [$];

  typedef struct {
    logic [N-1:0] word;
    int           gap;
    bit           bad_par;
    logic [N-1:0] exp_word;
    bit           exp_perr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic strobe(input logic b, input logic sync, input logic ack);
    bus.SerIn = b;
    bus.SerEn = 1'b1;
    bus.Sync  = sync;
    bus.Ack   = ack;
    @(posedge CLK); #1;
    bus.SerIn = 1'b0;
    bus.SerEn = 1'b0;
    bus.Sync  = 1'b0;
    bus.Ack   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic ack_cycle();
    bus.Ack = 1'b1;
    @(posedge CLK); #1;
    bus.Ack = 1'b0;
  endtask

  // Sends one frame MSB first with `gap` idle cycles between strobes; optional Ack on the final strobe.
  task automatic send_word(input logic [N-1:0] w, input int gap, input bit bad_par, input bit ack_last);
    exp_q.push_back(w);
    for (int i = N - 1; i >= 0; i--) begin
      strobe(w[i], 1'b0, ack_last && !PAR && (i == 0));
      if (!(i == 0 && !PAR) && gap > 0) begin
        idle(gap);
        if (i == N / 2) begin
          check("gap_busy", 32'(bus.Busy), 32'd1);
          check("gap_valid", 32'(bus.Valid), 32'd0);
        end
      end
    end
    if (PAR) strobe((^w) ^ bad_par, 1'b0, ack_last);
  endtask

  task automatic expect_word(input string name, input bit exp_perr);
    logic [N-1:0] e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s: scoreboard empty, got Q=%0h with nothing expected", name, bus.Q);
    end else begin
      e = exp_q.pop_front();
      check({name, "_valid"}, 32'(bus.Valid), 32'd1);
      check({name, "_q"}, 32'(bus.Q), 32'(e));
      check({name, "_parerr"}, 32'(bus.ParErr), 32'(exp_perr));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] w;
    vecs[0] = '{word: 8'hA6, gap: 0, bad_par: 1'b0, exp_word: 8'hA6, exp_perr: 1'b0};
    vecs[1] = '{word: 8'hA6, gap: 2, bad_par: 1'b0, exp_word: 8'hA6, exp_perr: 1'b0};
    vecs[2] = '{word: 8'hA6, gap: 0, bad_par: 1'b1, exp_word: 8'hA6, exp_perr: PAR};
    vecs[3] = '{word: 8'h00, gap: 1, bad_par: 1'b0, exp_word: 8'h00, exp_perr: 1'b0};
    vecs[4] = '{word: 8'h81, gap: 0, bad_par: 1'b1, exp_word: 8'h81, exp_perr: PAR};
    vecs[5] = '{word: 8'h3C, gap: 4, bad_par: 1'b0, exp_word: 8'h3C, exp_perr: 1'b0};

    bus.SerIn = 1'b0; bus.SerEn = 1'b0; bus.Sync = 1'b0; bus.Ack = 1'b0;
    RST = 1'b1;
    idle(2);
    check("rst_q", 32'(bus.Q), 32'd0);
    check("rst_valid", 32'(bus.Valid), 32'd0);
    check("rst_overrun", 32'(bus.Overrun), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_parerr", 32'(bus.ParErr), 32'd0);
    #2 RST = 1'b0;
    idle(1);

    foreach (vecs[i]) begin
      send_word(vecs[i].word, vecs[i].gap, vecs[i].bad_par, 1'b0);
      check("vec_busy_done", 32'(bus.Busy), 32'd0);
      check("vec_overrun", 32'(bus.Overrun), 32'd0);
      expect_word("vec", vecs[i].exp_perr);
      ack_cycle();
      check("vec_acked_valid", 32'(bus.Valid), 32'd0);
      check("vec_acked_q", 32'(bus.Q), 32'(vecs[i].exp_word));
      idle(1);
    end

    // Ack while nothing is pending is ignored.
    ack_cycle();
    check("stray_ack_valid", 32'(bus.Valid), 32'd0);
    check("stray_ack_overrun", 32'(bus.Overrun), 32'd0);

    // Back-to-back frames without Ack: overwrite sets Overrun, Ack clears it.
    send_word(8'hA6, 0, 1'b0, 1'b0);
    expect_word("b2b_first", 1'b0);
    send_word(8'h3C, 0, 1'b0, 1'b0);
    expect_word("b2b_second", 1'b0);
    check("b2b_overrun", 32'(bus.Overrun), 32'd1);
    ack_cycle();
    check("b2b_ack_valid", 32'(bus.Valid), 32'd0);
    check("b2b_ack_overrun", 32'(bus.Overrun), 32'd0);

    // Completion coinciding with Ack: new word, Valid stays, no overrun.
    send_word(8'h5A, 0, 1'b0, 1'b0);
    expect_word("coinc_first", 1'b0);
    send_word(8'hC3, 0, 1'b0, 1'b1);
    expect_word("coinc_second", 1'b0);
    check("coinc_overrun", 32'(bus.Overrun), 32'd0);
    ack_cycle();
    check("coinc_ack_valid", 32'(bus.Valid), 32'd0);

    // Partial word discarded by Sync, then a clean 0x0F.
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, 1'b0);
    check("sync_pre_busy", 32'(bus.Busy), 32'd1);
    bus.Sync = 1'b1;
    @(posedge CLK); #1;
    bus.Sync = 1'b0;
    check("sync_busy", 32'(bus.Busy), 32'd0);
    w = 8'h0F;
    exp_q.push_back(w);
    for (int i = N - 1; i >= 1; i--) strobe(w[i], 1'b0, 1'b0);
    check("sync_pre8_valid", 32'(bus.Valid), 32'd0);
    strobe(w[0], 1'b0, 1'b0);
    if (PAR) strobe(^w, 1'b0, 1'b0);
    expect_word("sync_word", 1'b0);
    ack_cycle();

    // Sync on what would be the completing strobe: no completion, that bit starts a new word.
    for (int i = 0; i < N + int'(PAR) - 1; i++) strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b1, 1'b0);
    check("sync_win_valid", 32'(bus.Valid), 32'd0);
    check("sync_win_q", 32'(bus.Q), 32'h0F);
    check("sync_win_busy", 32'(bus.Busy), 32'd1);
    w = 8'hC3;
    exp_q.push_back(w);
    for (int i = N - 2; i >= 0; i--) strobe(w[i], 1'b0, 1'b0);
    if (PAR) strobe(^w, 1'b0, 1'b0);
    expect_word("sync_win_word", 1'b0);
    ack_cycle();

    // Reset mid-word.
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 1'b0);
    check("midword_busy", 32'(bus.Busy), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("midword_rst_busy", 32'(bus.Busy), 32'd0);
    check("midword_rst_q", 32'(bus.Q), 32'd0);
    #1 RST = 1'b0;
    exp_q.delete();
    idle(1);

    // Reset while Valid=1 and Overrun=1.
    send_word(8'hF0, 0, 1'b0, 1'b0);
    expect_word("pre_rst_a", 1'b0);
    send_word(8'h0F, 0, 1'b1, 1'b0);
    expect_word("pre_rst_b", PAR);
    check("pre_rst_overrun", 32'(bus.Overrun), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("rst2_q", 32'(bus.Q), 32'd0);
    check("rst2_valid", 32'(bus.Valid), 32'd0);
    check("rst2_overrun", 32'(bus.Overrun), 32'd0);
    check("rst2_parerr", 32'(bus.ParErr), 32'd0);
    #1 RST = 1'b0;
    exp_q.delete();
    idle(1);
    send_word(8'h55, 0, 1'b0, 1'b0);
    expect_word("post_rst", 1'b0);
    check("post_rst_overrun", 32'(bus.Overrun), 32'd0);
    ack_cycle();
    check("post_rst_ack_valid", 32'(bus.Valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
